prod_accum: RTL
===============

PROD_ACCUM -- requirements
Module: prod_accum

Interface
REQ-001 SHALL have parameter PROD_W, default 8, giving the product input width (4x4 multiplier output).
REQ-002 SHALL have parameter ACC_W, default 12, giving the accumulator and result width; ACC_W >= PROD_W.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin a new accumulation run; sampled only in IDLE.
REQ-006 SHALL have port len  input  4  number of products per run; 0 encodes 16.
REQ-007 SHALL have port prod  input  PROD_W  unsigned product from the upstream multiplier.
REQ-008 SHALL have port prod_valid  input  1  prod is valid this cycle.
REQ-009 SHALL have port prod_ready  output  1  block accepts prod this cycle.
REQ-010 SHALL have port res  output  ACC_W  accumulated sum.
REQ-011 SHALL have port res_sat  output  1  the sum saturated during this run.
REQ-012 SHALL have port res_valid  output  1  res and res_sat are valid.
REQ-013 SHALL have port res_ready  input  1  downstream accepts the result.
REQ-014 SHALL have port busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 SHALL implement a registered FSM with the states IDLE, ACCUM and HOLD.
REQ-016 IDLE with start=1 SHALL latch the target count (len, or 16 when len=0), clear acc, count and sat, and move to ACCUM.
REQ-017 IDLE with start=0 SHALL remain in IDLE.
REQ-018 prod_ready SHALL be 1 exactly when the state is ACCUM, decoded from registered state only, with no combinational path from prod_valid.
REQ-019 A transfer SHALL occur on a cycle where prod_valid and prod_ready are both 1; cycles with prod_valid=0 SHALL leave acc and count unchanged.
REQ-020 On each transfer, acc SHALL become acc+prod, zero-extended to ACC_W+1 bits; if the sum exceeds 2^ACC_W-1, acc SHALL become 2^ACC_W-1 and sat SHALL set sticky for the run.
REQ-021 On the transfer where count equals target-1, the FSM SHALL move to HOLD; res_valid SHALL rise on the next cycle, giving a latency of 1 cycle after the final transfer.
REQ-022 In HOLD, res_valid SHALL be 1, res SHALL equal acc, and res_sat SHALL equal sat; all three SHALL stay stable until the handshake completes.
REQ-023 In HOLD, res_valid=1 with res_ready=1 SHALL complete the handshake and return the FSM to IDLE on the following edge.
REQ-024 When the FSM returns to IDLE, res_valid SHALL drop, and res and res_sat SHALL return to 0.
REQ-025 start SHALL be ignored in ACCUM and HOLD; a start arriving in the same cycle as the HOLD handshake SHALL be ignored, and a new run SHALL need start while in IDLE.
REQ-026 len SHALL be sampled only at start; later changes to len SHALL NOT affect a run in progress.
REQ-027 With default parameters, saturation SHALL be unreachable, since 16*225 = 3600 < 4096.
REQ-028 The count register SHALL be 5 bits wide and SHALL NOT wrap within a run.

Reset
REQ-029 rst_n=0 SHALL immediately, without waiting for clk, force state=IDLE, acc=0, count=0 and sat=0, and force all outputs (prod_ready, res, res_sat, res_valid, busy) to 0.
REQ-030 Reset asserted mid-run SHALL discard the partial sum; after release the block SHALL wait in IDLE for start.
REQ-031 Release of rst_n SHALL take effect on the first clk edge after deassertion, with no spurious transfer on that edge.

Verification
REQ-032 Bench SHALL cover: len=3, prods 225,225,225 back-to-back -> res=675, res_sat=0, res_valid high 1 cycle after the third transfer.
REQ-033 Bench SHALL cover: len=0, sixteen prods of 225 -> exactly 16 transfers accepted, res=3600, res_sat=0.
REQ-034 Bench SHALL cover: ACC_W=8, len=2, prods 200 then 100 -> res=255, res_sat=1.
REQ-035 Bench SHALL cover: len=4 with prod_valid low on alternating cycles, prods 1,2,3,4 -> res=10, and bubbles are not counted.
REQ-036 Bench SHALL cover: HOLD with res_ready held low 5 cycles plus start pulses -> res stable, FSM stays in HOLD; res_ready=1 -> IDLE next cycle.
REQ-037 Bench SHALL cover: rst_n pulsed low after 2 of 4 transfers -> all outputs 0 asynchronously; then start, len=1, prod=7 -> res=7.

Source files
------------

// File: rtl/prod_accum_if.sv
// rtl/prod_accum_if.sv - product-in / result-out handshake bundle for prod_accum
interface prod_accum_if #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
);
    logic              start;
    logic [3:0]        len;
    logic [PROD_W-1:0] prod;
    logic              prod_valid;
    logic              prod_ready;
    logic [ACC_W-1:0]  res;
    logic              res_sat;
    logic              res_valid;
    logic              res_ready;
    logic              busy;

    // Upstream controller / downstream consumer side
    modport master (
        output start, len, prod, prod_valid, res_ready,
        input  prod_ready, res, res_sat, res_valid, busy
    );

    // Accumulator side
    modport slave (
        input  start, len, prod, prod_valid, res_ready,
        output prod_ready, res, res_sat, res_valid, busy
    );
endinterface

// File: rtl/prod_accum.sv
// rtl/prod_accum.sv - saturating accumulator of a fixed-length run of unsigned products
module prod_accum #(
    parameter int PROD_W = 8,
    parameter int ACC_W  = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    prod_accum_if.slave  bus
);
    // Zero-extension needed to bring a product up to the ACC_W+1 bit sum width
    localparam int EXT_W = ACC_W + 1 - PROD_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [ACC_W-1:0] acc;
    logic [4:0]       count;
    logic [4:0]       target;
    logic             sat;
    logic [ACC_W:0]   sum;
    logic             xfer;
    logic             last_xfer;

    // A transfer needs ACCUM (which is what prod_ready reports) and a valid product
    assign xfer      = (state == ACCUM) && bus.prod_valid;
    assign last_xfer = xfer && (count == target - 5'd1);
    // One spare carry bit tells us the sum no longer fits in ACC_W
    assign sum       = {1'b0, acc} + {{EXT_W{1'b0}}, bus.prod};

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode; start only matters in IDLE
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = ACCUM;
            ACCUM:   if (last_xfer) state_next = HOLD;
            HOLD:    if (bus.res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decoded from registered state only; result fields read zero outside HOLD
    always_comb begin
        bus.prod_ready = (state == ACCUM);
        bus.res_valid  = (state == HOLD);
        bus.res        = (state == HOLD) ? acc : '0;
        bus.res_sat    = (state == HOLD) && sat;
        bus.busy       = (state != IDLE);
    end

    // Run datapath: latch target at start, accumulate with sticky saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            count  <= '0;
            target <= '0;
            sat    <= 1'b0;
        end else if (state == IDLE) begin
            if (bus.start) begin
                target <= (bus.len == 4'd0) ? 5'd16 : {1'b0, bus.len};
                acc    <= '0;
                count  <= '0;
                sat    <= 1'b0;
            end
        end else if (xfer) begin
            count <= count + 5'd1;
            if (sum[ACC_W]) begin
                acc <= '1;
                sat <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end
endmodule
